// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared OSPFB constants plus the types and helpers used by the sample source.
// Defaults here feed the module parameters.
package alpaca_ospfb_constants_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_DEC_FAC = 384;

    typedef enum logic [1:0] {
        RAMP    = 2'd0,
        IMPULSE = 2'd1,
        CONST   = 2'd2,
        ALT     = 2'd3
    } src_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } src_state_t;

    // Negate a w-bit signed value (carried sign-extended in 64 bits);
    // the most negative value maps to the most positive instead of overflowing.
    function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x, input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        return (x == min_v) ? max_v : -x;
    endfunction

endpackage

// File: rtl/ospfb_sample_src.sv
// AXI4-Stream test-pattern source: frames of DEC_FAC samples with tlast on the
// final one, for a programmed number of frames or free-running.
module ospfb_sample_src
    import alpaca_ospfb_constants_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int DEC_FAC       = DEFAULT_DEC_FAC,
    parameter int FRAME_CNT_WID = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         amp,
    input  logic [FRAME_CNT_WID-1:0] nframes,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (DEC_FAC > 1) ? $clog2(DEC_FAC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEC_FAC - 1);

    function automatic logic signed [WIDTH-1:0] pattern(input src_mode_t m,
                                                        input logic signed [WIDTH-1:0] a,
                                                        input logic [IDX_W-1:0] n);
        logic signed [WIDTH-1:0] p;
        logic signed [WIDTH-1:0] neg;
        neg = WIDTH'(sat_neg(64'(a), WIDTH));
        case (m)
            RAMP:    p = WIDTH'(n);
            IMPULSE: p = (n == '0) ? a : '0;
            CONST:   p = a;
            default: p = n[0] ? neg : a;
        endcase
        return p;
    endfunction

    src_state_t               state_q, state_d;
    src_mode_t                mode_q, mode_d;
    logic signed [WIDTH-1:0]  amp_q, amp_d;
    logic [FRAME_CNT_WID-1:0] nframes_q, nframes_d;
    logic [FRAME_CNT_WID-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [WIDTH-1:0]  tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     xfer;
    logic [IDX_W-1:0]         idx_nxt;
    logic [FRAME_CNT_WID-1:0] frame_inc;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        amp_d     = amp_q;
        nframes_d = nframes_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = done_q;

        xfer      = tvalid_q && m_tready;
        idx_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        frame_inc = frame_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = RUN;
                    mode_d    = src_mode_t'(mode);
                    amp_d     = $signed(amp);
                    nframes_d = nframes;
                    frame_d   = '0;
                    idx_d     = '0;
                    tdata_d   = pattern(src_mode_t'(mode), $signed(amp), '0);
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            RUN, DRAIN: begin
                // A tlast transfer is a frame boundary; it outranks a falling en.
                if (xfer && tlast_q) begin
                    frame_d = frame_inc;
                    idx_d   = '0;
                    if ((nframes_q != '0) && (frame_inc == nframes_q)) begin
                        state_d  = DONE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else if (!en || (state_q == DRAIN)) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                    end else begin
                        tdata_d = pattern(mode_q, amp_q, '0);
                        tlast_d = 1'b0;
                    end
                end else begin
                    if (xfer) begin
                        idx_d   = idx_nxt;
                        tdata_d = pattern(mode_q, amp_q, idx_nxt);
                        tlast_d = (idx_nxt == LAST_IDX);
                    end
                    if (!en) begin
                        state_d = DRAIN;
                    end
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    frame_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= RAMP;
            amp_q     <= '0;
            nframes_q <= '0;
            frame_q   <= '0;
            idx_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            amp_q     <= amp_d;
            nframes_q <= nframes_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ospfb_sample_src.sv
// Bench for ospfb_sample_src: a frame/beat level model checked every cycle,
// plus literal expectations on the captured transfer sequences.
module tb_ospfb_sample_src;

    localparam int W  = 16;
    localparam int DF = 4;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  amp;
    logic [FW-1:0] nframes;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ospfb_sample_src #(.WIDTH(W), .DEC_FAC(DF), .FRAME_CNT_WID(FW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .amp      (amp),
        .nframes  (nframes),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .done     (done)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Model: active = a frame stream is being offered, fin = finished run held.
    bit md_act, md_stop, md_fin;
    int md_n, md_frames, md_mode, md_amp, md_nf;

    bit           prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;
    int           got_data[$];
    bit           got_last[$];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_sample(input int m, input int a, input int n);
        int maxv;
        maxv = (1 << (W - 1)) - 1;
        case (m)
            0:       return n;
            1:       return (n == 0) ? a : 0;
            2:       return a;
            default: return (n % 2 == 0) ? a : ((-a > maxv) ? maxv : -a);
        endcase
    endfunction

    // One clock: check outputs at the falling edge, advance the model with the
    // inputs the next rising edge will sample, then return 1 time unit after it.
    task automatic step();
        @(negedge clk);
        if (!rst_n) begin
            check("reset_ctrl", {m_tvalid, m_tlast, busy, done}, 0);
            check("reset_data", m_tdata, 0);
            md_act = 0; md_stop = 0; md_fin = 0; md_n = 0; md_frames = 0;
            prev_stall = 0;
        end else begin
            check("ctrl_valid_busy_done", {m_tvalid, busy, done}, {md_act, md_act, md_fin});
            if (m_tvalid) begin
                check("data", $signed(m_tdata), model_sample(md_mode, md_amp, md_n));
                check("last", m_tlast, (md_n == DF - 1));
                if (prev_stall) begin
                    check("stall_hold_data", m_tdata, prev_data);
                    check("stall_hold_last", m_tlast, prev_last);
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (m_tvalid && m_tready) begin
                got_data.push_back(int'($signed(m_tdata)));
                got_last.push_back(m_tlast);
            end
            if (md_fin) begin
                if (!en) begin
                    md_fin = 0;
                    md_frames = 0;
                end
            end else if (!md_act) begin
                if (en) begin
                    md_act = 1; md_stop = 0; md_n = 0; md_frames = 0;
                    md_mode = int'(mode); md_amp = int'($signed(amp)); md_nf = int'(nframes);
                end
            end else if (m_tready && md_n == DF - 1) begin
                md_frames++;
                md_n = 0;
                if (md_nf != 0 && md_frames == md_nf) begin
                    md_act = 0;
                    md_fin = 1;
                end else if (!en || md_stop) begin
                    md_act = 0;
                end
            end else begin
                if (m_tready) md_n++;
                if (!en) md_stop = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_data.delete();
        got_last.delete();
    endtask

    int e_ramp[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int e_imp[12]  = '{100, 0, 0, 0, 100, 0, 0, 0, 100, 0, 0, 0};
    int e_alt[4]   = '{-32768, 32767, -32768, 32767};

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; amp = '0; nframes = '0; m_tready = 1'b0;
        md_act = 0; md_stop = 0; md_fin = 0; md_n = 0; md_frames = 0;
        md_mode = 0; md_amp = 0; md_nf = 0; prev_stall = 0;
        #1;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // RAMP, two frames, no backpressure
        clear_got();
        mode = 2'd0; nframes = 2; m_tready = 1'b1; en = 1'b1;
        repeat (12) step();
        check("ramp_beats", got_data.size(), 8);
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            check("ramp_data", got_data[i], e_ramp[i]);
            check("ramp_last", got_last[i], (i == 3 || i == 7));
        end
        check("ramp_done", done, 1);
        check("ramp_busy", busy, 0);
        en = 1'b0;
        repeat (2) step();

        // IMPULSE, three frames, ready toggling
        clear_got();
        mode = 2'd1; amp = 16'd100; nframes = 3; en = 1'b1;
        for (int i = 0; i < 34; i++) begin
            m_tready = (i % 2 == 0);
            step();
        end
        check("imp_beats", got_data.size(), 12);
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check("imp_data", got_data[i], e_imp[i]);
            check("imp_last", got_last[i], (i % 4 == 3));
        end
        check("imp_done", done, 1);
        en = 1'b0; m_tready = 1'b1;
        repeat (2) step();

        // ALT at the most negative amplitude
        clear_got();
        mode = 2'd3; amp = 16'h8000; nframes = 1; en = 1'b1;
        repeat (8) step();
        check("alt_beats", got_data.size(), 4);
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            check("alt_data", got_data[i], e_alt[i]);
            check("alt_last", got_last[i], (i == 3));
        end
        check("alt_done", done, 1);
        en = 1'b0;
        repeat (2) step();

        // CONST free-running, en dropped mid frame 3: frame completes, no done
        clear_got();
        mode = 2'd2; amp = 16'd5; nframes = 0; en = 1'b1;
        for (int i = 0; i < 40 && got_data.size() < 10; i++) step();
        check("const_reach_beat10", got_data.size(), 10);
        en = 1'b0;
        repeat (6) step();
        check("const_beats", got_data.size(), 12);
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check("const_data", got_data[i], 5);
            check("const_last", got_last[i], (i % 4 == 3));
        end
        check("const_done", done, 0);
        check("const_valid_off", m_tvalid, 0);

        // Asynchronous reset mid-frame, then restart from n=0
        clear_got();
        mode = 2'd0; nframes = 0; en = 1'b1;
        for (int i = 0; i < 20 && got_data.size() < 2; i++) step();
        check("rst_mid_frame_reached", got_data.size(), 2);
        check("rst_mid_frame_valid", m_tvalid, 1);
        rst_n = 1'b0;
        repeat (3) step();
        clear_got();
        rst_n = 1'b1;
        repeat (3) step();
        check("rst_restart_beats", got_data.size(), 2);
        if (got_data.size() >= 2) begin
            check("rst_restart_first", got_data[0], 0);
            check("rst_restart_second", got_data[1], 1);
        end
        en = 1'b0;
        repeat (6) step();

        // DONE hold with en high, release, fresh frame
        clear_got();
        mode = 2'd0; nframes = 1; en = 1'b1;
        repeat (12) step();
        check("hold_beats", got_data.size(), 4);
        check("hold_done", done, 1);
        check("hold_valid", m_tvalid, 0);
        en = 1'b0;
        repeat (2) step();
        check("hold_released_done", done, 0);
        clear_got();
        en = 1'b1;
        repeat (3) step();
        check("fresh_beats", got_data.size(), 2);
        if (got_data.size() >= 1) begin
            check("fresh_first", got_data[0], 0);
            check("fresh_first_last", got_last[0], 0);
        end
        en = 1'b0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
